// File: rtl/sparc_ifu_milq_pkg.sv
// ============================================================================
// Module   : sparc_ifu_milq_pkg
// Brief    : Shared IFU miss-list constants and per-entry state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sparc_ifu_milq_pkg;

   localparam int MILQ_NENT = 4;
   localparam int MILQ_PAW  = 35;

   typedef enum logic [2:0] {
      MILQ_IDLE  = 3'd0,
      MILQ_REQ   = 3'd1,
      MILQ_WAIT  = 3'd2,
      MILQ_FILL1 = 3'd3,
      MILQ_DUP   = 3'd4
   } milq_state_e;

endpackage

`default_nettype wire

// File: rtl/sparc_ifu_milq_ent.sv
// ============================================================================
// Module   : sparc_ifu_milq_ent
// Brief    : One miss-list entry: state, line address and parent thread.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sparc_ifu_milq_ent
   import sparc_ifu_milq_pkg::*;
(
   input  logic                rclk,
   input  logic                reset,
   input  logic                i_accept,
   input  logic                i_dup,
   input  logic [1:0]          i_dup_par,
   input  logic [MILQ_PAW-1:0] i_miss_pa,
   input  logic                i_gnt_ack,
   input  logic                i_fill,
   input  logic [MILQ_NENT-1:0] i_par_done,
   output milq_state_e         o_state,
   output logic [MILQ_PAW-1:0] o_pa,
   output logic [1:0]          o_par_tid
);

   milq_state_e         r_state;
   milq_state_e         w_nxt;
   logic [MILQ_PAW-1:0] r_pa;
   logic [1:0]          r_par_tid;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         MILQ_IDLE:  if (i_accept)  w_nxt = i_dup ? MILQ_DUP : MILQ_REQ;
         MILQ_REQ:   if (i_gnt_ack) w_nxt = MILQ_WAIT;
         MILQ_WAIT:  if (i_fill)    w_nxt = MILQ_FILL1;
         MILQ_FILL1: if (i_fill)    w_nxt = MILQ_IDLE;
         // a duplicate retires on the same edge as its parent's last beat
         MILQ_DUP:   if (i_par_done[r_par_tid]) w_nxt = MILQ_IDLE;
         default:    w_nxt = MILQ_IDLE;
      endcase
   end

   always_ff @(posedge rclk) begin
      if (reset) begin
         r_state   <= MILQ_IDLE;
         r_pa      <= '0;
         r_par_tid <= '0;
      end else begin
         r_state <= w_nxt;
         if (i_accept) begin
            r_pa      <= i_miss_pa;
            r_par_tid <= i_dup_par;
         end
      end
   end

   assign o_state   = r_state;
   assign o_pa      = r_pa;
   assign o_par_tid = r_par_tid;

endmodule

`default_nettype wire

// File: rtl/sparc_ifu_milq.sv
// ============================================================================
// Module   : sparc_ifu_milq
// Brief    : Four-entry IFU miss instruction list with duplicate detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sparc_ifu_milq
   import sparc_ifu_milq_pkg::*;
(
   input  logic                 rclk,
   input  logic                 reset,
   input  logic                 miss_vld,
   input  logic [1:0]           miss_tid,
   input  logic [MILQ_PAW-1:0]  miss_pa,
   input  logic                 req_ack,
   input  logic                 fill_vld,
   input  logic [1:0]           fill_tid,
   output logic                 req_vld,
   output logic [1:0]           req_tid,
   output logic [MILQ_PAW-1:0]  req_pa,
   output logic [MILQ_NENT-1:0] mil_busy,
   output logic [MILQ_NENT-1:0] mil_done,
   output logic                 dup_hit,
   output logic                 mil_err
);

   milq_state_e         w_state   [MILQ_NENT];
   logic [MILQ_PAW-1:0] w_pa      [MILQ_NENT];
   logic [1:0]          w_par_tid [MILQ_NENT];

   logic [MILQ_NENT-1:0] w_idle, w_reqs, w_accept, w_fill_sel, w_fin;
   logic [MILQ_NENT-1:0] w_match, w_release, w_gnt_ack, w_fill_ok;
   logic                 w_dup;
   logic [1:0]           w_dup_par;
   logic [1:0]           w_rr_tid;
   logic [1:0]           w_gnt;
   logic                 w_err_nxt;

   logic [1:0]           r_ptr;
   logic                 r_lock;
   logic [1:0]           r_lock_tid;
   logic [MILQ_NENT-1:0] r_done;
   logic                 r_dup;
   logic                 r_err;

   genvar gi;
   generate
      for (gi = 0; gi < MILQ_NENT; gi++) begin : g_ent
         assign w_idle[gi]     = (w_state[gi] == MILQ_IDLE);
         assign w_reqs[gi]     = (w_state[gi] == MILQ_REQ);
         assign w_accept[gi]   = miss_vld && (miss_tid == 2'(gi)) && w_idle[gi];
         assign w_fill_sel[gi] = fill_vld && (fill_tid == 2'(gi));
         assign w_fill_ok[gi]  = (w_state[gi] == MILQ_WAIT) || (w_state[gi] == MILQ_FILL1);
         assign w_fin[gi]      = w_fill_sel[gi] && (w_state[gi] == MILQ_FILL1);
         // a parent finishing this edge is no longer a valid duplicate target
         assign w_match[gi]    = (w_reqs[gi] || w_fill_ok[gi]) && !w_fin[gi] &&
                                 (w_pa[gi] == miss_pa);
         assign w_release[gi]  = (w_state[gi] == MILQ_DUP) && w_fin[w_par_tid[gi]];
         assign w_gnt_ack[gi]  = req_vld && req_ack && (w_gnt == 2'(gi));

         sparc_ifu_milq_ent u_ent (
            .rclk       (rclk),
            .reset      (reset),
            .i_accept   (w_accept[gi]),
            .i_dup      (w_dup),
            .i_dup_par  (w_dup_par),
            .i_miss_pa  (miss_pa),
            .i_gnt_ack  (w_gnt_ack[gi]),
            .i_fill     (w_fill_sel[gi]),
            .i_par_done (w_fin),
            .o_state    (w_state[gi]),
            .o_pa       (w_pa[gi]),
            .o_par_tid  (w_par_tid[gi])
         );
      end
   endgenerate

   assign w_dup = |w_match;

   always_comb begin : p_dup_pick
      w_dup_par = 2'd0;
      for (int k = MILQ_NENT - 1; k >= 0; k--) begin
         if (w_match[k]) w_dup_par = k[1:0];
      end
   end

   always_comb begin : p_rr_pick
      logic       v_found;
      logic [1:0] v_idx;
      v_found  = 1'b0;
      v_idx    = 2'd0;
      w_rr_tid = 2'd0;
      for (int k = 0; k < MILQ_NENT; k++) begin
         v_idx = r_ptr + k[1:0];
         if (!v_found && w_reqs[v_idx]) begin
            v_found  = 1'b1;
            w_rr_tid = v_idx;
         end
      end
   end

   // an unacked grant is pinned so later arrivals cannot disturb tid/pa
   assign w_gnt   = r_lock ? r_lock_tid : w_rr_tid;
   assign req_vld = |w_reqs;
   assign req_tid = w_gnt;
   assign req_pa  = w_pa[w_gnt];

   assign w_err_nxt = (miss_vld && !w_idle[miss_tid]) ||
                      (fill_vld && !w_fill_ok[fill_tid]);

   always_ff @(posedge rclk) begin
      if (reset) begin
         r_ptr      <= 2'd0;
         r_lock     <= 1'b0;
         r_lock_tid <= 2'd0;
         r_done     <= '0;
         r_dup      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (req_vld && req_ack) begin
            r_lock <= 1'b0;
            r_ptr  <= w_gnt + 2'd1;
         end else if (req_vld) begin
            r_lock     <= 1'b1;
            r_lock_tid <= w_gnt;
         end else begin
            r_lock <= 1'b0;
         end
         r_done <= w_fin | w_release;
         r_dup  <= (|w_accept) && w_dup;
         r_err  <= w_err_nxt;
      end
   end

   always_comb begin
      for (int k = 0; k < MILQ_NENT; k++) mil_busy[k] = !w_idle[k];
   end

   assign mil_done = r_done;
   assign dup_hit  = r_dup;
   assign mil_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sparc_ifu_milq.sv
// ============================================================================
// Module   : tb_sparc_ifu_milq
// Brief    : Directed and randomized checks of the miss list against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sparc_ifu_milq;

   logic        rclk = 1'b0;
   logic        reset = 1'b1;
   logic        miss_vld = 1'b0;
   logic [1:0]  miss_tid = 2'd0;
   logic [34:0] miss_pa = '0;
   logic        req_ack = 1'b0;
   logic        fill_vld = 1'b0;
   logic [1:0]  fill_tid = 2'd0;
   logic        req_vld;
   logic [1:0]  req_tid;
   logic [34:0] req_pa;
   logic [3:0]  mil_busy;
   logic [3:0]  mil_done;
   logic        dup_hit;
   logic        mil_err;

   int checks = 0;
   int errors = 0;

   sparc_ifu_milq dut (
      .rclk     (rclk),
      .reset    (reset),
      .miss_vld (miss_vld),
      .miss_tid (miss_tid),
      .miss_pa  (miss_pa),
      .req_ack  (req_ack),
      .fill_vld (fill_vld),
      .fill_tid (fill_tid),
      .req_vld  (req_vld),
      .req_tid  (req_tid),
      .req_pa   (req_pa),
      .mil_busy (mil_busy),
      .mil_done (mil_done),
      .dup_hit  (dup_hit),
      .mil_err  (mil_err)
   );

   initial forever #5 rclk = ~rclk;

   // model: each thread is busy/free, waits for an ack, then counts fill beats;
   // a duplicate simply remembers which thread owns its line
   bit          m_busy  [4];
   bit          m_acked [4];
   int          m_beats [4];
   int          m_par   [4];
   logic [34:0] m_pa    [4];
   int          m_ptr;
   bit          m_lock;
   int          m_lock_tid;
   logic [3:0]  e_done;
   bit          e_dup, e_err;

   function automatic bit m_owner(int t);
      return m_busy[t] && (m_par[t] < 0);
   endfunction

   function automatic bit m_reqing(int t);
      return m_owner(t) && !m_acked[t];
   endfunction

   function automatic bit m_any_req();
      bit r = 0;
      for (int t = 0; t < 4; t++) r |= m_reqing(t);
      return r;
   endfunction

   function automatic int m_gnt();
      if (m_lock) return m_lock_tid;
      for (int k = 0; k < 4; k++) if (m_reqing((m_ptr + k) % 4)) return (m_ptr + k) % 4;
      return 0;
   endfunction

   function automatic void m_clear();
      for (int t = 0; t < 4; t++) begin
         m_busy[t] = 0; m_acked[t] = 0; m_beats[t] = 0; m_par[t] = -1; m_pa[t] = '0;
      end
      m_ptr = 0; m_lock = 0; m_lock_tid = 0;
      e_done = '0; e_dup = 0; e_err = 0;
   endfunction

   function automatic void m_update(bit rs, bit mv, int mt, logic [34:0] mp, bit ak, bit fv, int ft);
      bit fin [4];
      bit rel [4];
      int g, mdup;
      bit rv, macc;
      if (rs) begin
         m_clear();
         return;
      end
      e_done = '0; e_dup = 0; e_err = 0;
      g  = m_gnt();
      rv = m_any_req();
      for (int t = 0; t < 4; t++)
         fin[t] = fv && (ft == t) && m_owner(t) && m_acked[t] && (m_beats[t] == 1);
      for (int t = 0; t < 4; t++)
         rel[t] = m_busy[t] && (m_par[t] >= 0) && fin[m_par[t]];
      macc = 0; mdup = -1;
      if (mv) begin
         if (m_busy[mt]) e_err = 1;
         else begin
            macc = 1;
            for (int t = 0; t < 4; t++)
               if (mdup < 0 && m_owner(t) && !fin[t] && m_pa[t] == mp) mdup = t;
         end
      end
      if (fv) begin
         if (m_owner(ft) && m_acked[ft] && m_beats[ft] == 0) m_beats[ft] = 1;
         else if (!fin[ft]) e_err = 1;
      end
      if (rv && ak) begin
         m_acked[g] = 1; m_ptr = (g + 1) % 4; m_lock = 0;
      end else if (rv) begin
         m_lock = 1; m_lock_tid = g;
      end else m_lock = 0;
      for (int t = 0; t < 4; t++) begin
         if (fin[t] || rel[t]) begin
            m_busy[t] = 0; m_acked[t] = 0; m_beats[t] = 0; m_par[t] = -1;
            e_done[t] = 1'b1;
         end
      end
      if (macc) begin
         m_busy[mt] = 1; m_acked[mt] = 0; m_beats[mt] = 0; m_par[mt] = mdup; m_pa[mt] = mp;
         e_dup = (mdup >= 0);
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [3:0] eb;
      bit         ev;
      for (int t = 0; t < 4; t++) eb[t] = m_busy[t];
      ev = m_any_req();
      chk("busy", 64'(mil_busy), 64'(eb));
      chk("req_vld", 64'(req_vld), 64'(ev));
      chk("done", 64'(mil_done), 64'(e_done));
      chk("dup_hit", 64'(dup_hit), 64'(e_dup));
      chk("mil_err", 64'(mil_err), 64'(e_err));
      if (ev) begin
         chk("req_tid", 64'(req_tid), 64'(m_gnt()));
         chk("req_pa", 64'(req_pa), 64'(m_pa[m_gnt()]));
      end
   endtask

   task automatic step(input bit rs, input bit mv, input logic [1:0] mt, input logic [34:0] mp,
                       input bit ak, input bit fv, input logic [1:0] ft);
      reset = rs; miss_vld = mv; miss_tid = mt; miss_pa = mp;
      req_ack = ak; fill_vld = fv; fill_tid = ft;
      m_update(rs, mv, int'(mt), mp, ak, fv, int'(ft));
      @(posedge rclk);
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(0, 0, 2'd0, '0, 0, 0, 2'd0);
   endtask

   task automatic miss(input logic [1:0] t, input logic [34:0] pa, input bit ak);
      step(0, 1, t, pa, ak, 0, 2'd0);
   endtask

   task automatic ack();
      step(0, 0, 2'd0, '0, 1, 0, 2'd0);
   endtask

   task automatic fill(input logic [1:0] t);
      step(0, 0, 2'd0, '0, 0, 1, t);
   endtask

   localparam logic [34:0] PA_A = 35'h0_1234_5678;
   localparam logic [34:0] PA_B = 35'h5_0000_00a1;
   localparam logic [34:0] PA_C = 35'h2_dead_beef;
   localparam logic [34:0] PA_D = 35'h7_ffff_fff0;

   logic [34:0] pool [4];

   initial begin
      bit         rs, mv, ak, fv;
      logic [1:0] mt, ft;
      int         st;
      m_clear();

      // single miss
      step(1, 0, 2'd0, '0, 0, 0, 2'd0);
      chk("rst_busy", 64'(mil_busy), 64'h0);
      miss(2'd1, PA_A, 0);
      chk("sm_vld", 64'(req_vld), 64'h1);
      chk("sm_tid", 64'(req_tid), 64'h1);
      chk("sm_pa", 64'(req_pa), 64'(PA_A));
      ack();
      chk("sm_ack", 64'(req_vld), 64'h0);
      fill(2'd1);
      fill(2'd1);
      chk("sm_done", 64'(mil_done), 64'b0010);
      chk("sm_busy", 64'(mil_busy), 64'h0);

      // duplicate
      miss(2'd0, PA_A, 0);
      ack();
      miss(2'd2, PA_A, 0);
      chk("dup_hit1", 64'(dup_hit), 64'h1);
      chk("dup_noreq", 64'(req_vld), 64'h0);
      fill(2'd0);
      fill(2'd0);
      chk("dup_done", 64'(mil_done), 64'b0101);

      // round-robin with ack held high
      miss(2'd0, PA_A, 1);  chk("rr0", 64'(req_tid), 64'h0);
      miss(2'd1, PA_B, 1);  chk("rr1", 64'(req_tid), 64'h1);
      miss(2'd2, PA_C, 1);  chk("rr2", 64'(req_tid), 64'h2);
      miss(2'd3, PA_D, 1);  chk("rr3", 64'(req_tid), 64'h3);
      ack();
      for (int t = 0; t < 4; t++) begin
         fill(2'(t));
         fill(2'(t));
      end
      // stability while unacked, even after a higher-priority arrival
      miss(2'd2, PA_C, 0);
      miss(2'd1, PA_B, 0);
      for (int n = 0; n < 3; n++) begin
         idle();
         chk("hold_tid", 64'(req_tid), 64'h2);
         chk("hold_pa", 64'(req_pa), 64'(PA_C));
      end
      ack();
      chk("rr_next", 64'(req_tid), 64'h1);
      ack();

      // boundaries: miss to busy thread, fill to idle thread
      miss(2'd0, PA_B, 0);
      miss(2'd0, PA_D, 0);
      chk("busy_err", 64'(mil_err), 64'h1);
      chk("busy_pa", 64'(req_pa), 64'(PA_B));
      fill(2'd3);
      chk("idle_fill_err", 64'(mil_err), 64'h1);
      chk("idle_fill_busy3", 64'(mil_busy[3]), 64'h0);
      ack();
      fill(2'd0); fill(2'd0); fill(2'd1); fill(2'd1); fill(2'd2); fill(2'd2);
      chk("clean_busy", 64'(mil_busy), 64'h0);

      // miss racing the parent's final beat
      miss(2'd0, PA_D, 0);
      ack();
      fill(2'd0);
      step(0, 1, 2'd1, PA_D, 0, 1, 2'd0);
      chk("race_dup", 64'(dup_hit), 64'h0);
      chk("race_tid", 64'(req_tid), 64'h1);
      chk("race_done", 64'(mil_done), 64'b0001);
      ack();
      fill(2'd1); fill(2'd1);

      // reset mid-operation
      miss(2'd0, PA_A, 0);
      ack();
      fill(2'd0);
      miss(2'd2, PA_B, 0);
      step(1, 0, 2'd0, '0, 0, 0, 2'd0);
      chk("mrst_busy", 64'(mil_busy), 64'h0);
      chk("mrst_vld", 64'(req_vld), 64'h0);
      chk("mrst_done", 64'(mil_done), 64'h0);
      fill(2'd0);
      chk("mrst_err", 64'(mil_err), 64'h1);

      // randomized traffic against the model
      for (int t = 0; t < 4; t++) pool[t] = {3'($urandom), 32'($urandom)};
      for (int n = 0; n < 800; n++) begin
         rs = ($urandom % 150) == 0;
         mv = ($urandom % 2) == 0;
         mt = 2'($urandom);
         ak = ($urandom % 2) == 0;
         fv = ($urandom % 3) == 0;
         ft = 2'($urandom);
         if (fv && ($urandom % 4) != 0) begin
            st = int'($urandom % 4);
            for (int k = 0; k < 4; k++)
               if (m_owner((st + k) % 4) && m_acked[(st + k) % 4]) ft = 2'((st + k) % 4);
         end
         if (fv && ak && m_any_req() && int'(ft) == m_gnt()) fv = 0;
         step(rs, mv, mt, pool[$urandom % 4], ak, fv, ft);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sparc_ifu_milq.md
Name: sparc_ifu_milq

Overview:
- Four-entry miss instruction list (MIL) for the IFU; one entry per thread (entry index = thread id).
- Records each I-cache miss physical line address PA[39:5] (35 bits).
- Detects duplicate misses to an already-outstanding line.
- Issues one L2 request per unique line with a valid/ack handshake, tracks the 2-beat fill and signals completion per thread.
- Sits between the I-cache miss detect logic (upstream) and the IFQ/L2 request interface (downstream).

Parameters:
- NENT, 4, number of entries/threads; fixed at 4 (tid width 2).
- PAW, 35, width of stored line address (PA[39:5]).

Ports:
- rclk  in  1  clock
- reset  in  1  synchronous active-high reset
- miss_vld  in  1  new I-cache miss this cycle
- miss_tid  in  2  thread of the miss
- miss_pa  in  35  line address of the miss
- req_ack  in  1  downstream accepted current request
- fill_vld  in  1  one fill beat returning
- fill_tid  in  2  thread the fill beat belongs to
- req_vld  out  1  request to L2 pending
- req_tid  out  2  thread of pending request
- req_pa  out  35  line address of pending request
- mil_busy  out  4  per-thread entry not IDLE
- mil_done  out  4  per-thread one-cycle completion pulse
- dup_hit  out  1  one-cycle pulse: accepted miss matched an outstanding line
- mil_err  out  1  one-cycle pulse: protocol violation (miss or fill dropped)

Behaviour:
- Per-entry state: IDLE, REQ, WAIT, FILL1, DUP. Each entry also holds pa[34:0] and par_tid[1:0].
- Reset (synchronous, any cycle, including mid-operation):
  - All entries go to IDLE; the round-robin pointer goes to 0.
  - All outputs read 0 from the next cycle. Any pending fill or request is forgotten.
- Miss accept: miss_vld with entry[miss_tid] IDLE writes pa at the clock edge.
  - Duplicate check: compare miss_pa (full 35-bit equality) against every entry in REQ, WAIT or FILL1 that is not completing this cycle.
  - Match: the entry goes to DUP with par_tid = matching entry, and dup_hit pulses the next cycle.
  - No match: the entry goes to REQ.
  - If several entries match, the lowest tid wins.
  - DUP entries are never compared, so there is no chaining.
- Miss to a non-IDLE entry: ignored, and mil_err pulses the next cycle.
- Request:
  - req_vld = any entry in REQ. The grant is round-robin starting at the pointer.
  - req_tid and req_pa come from the granted entry and are driven only from registered state (no combinational path from inputs).
  - On req_ack with req_vld: the granted entry goes REQ->WAIT and the pointer moves to granted tid+1 (mod 4).
  - req_vld, req_tid and req_pa stay stable until acked. req_ack while req_vld=0 is ignored.
  - A newly accepted miss can raise req_vld no earlier than the cycle after miss_vld.
- Fill:
  - fill_vld for an entry in WAIT: WAIT->FILL1.
  - fill_vld for an entry in FILL1: the entry goes to IDLE (completion).
  - fill_vld for an entry in any other state: ignored, and mil_err pulses.
- Completion:
  - mil_done[t] pulses in the cycle after the final fill beat.
  - In the same edge, every DUP entry with par_tid = t goes to IDLE, and its mil_done bit pulses together with the parent's.
- Simultaneous events:
  - A miss in the same cycle as a parent's final fill beat sees that parent as non-matching and goes to REQ.
  - A miss and an ack or fill to different entries in the same cycle are all honoured.
  - Ack and fill cannot target the same entry in one cycle; a fill in REQ is an error.
- mil_busy[t] = entry t not IDLE, registered.

Decomposition:
- Shared IFU package holds:
  - state encodings MILQ_IDLE=3'd0, REQ=3'd1, WAIT=3'd2, FILL1=3'd3, DUP=3'd4;
  - constants MILQ_NENT=4 and MILQ_PAW=35.
- One sub-module, sparc_ifu_milq_ent, replicated 4 times. It holds the per-entry state register, pa and par_tid, and computes its next state from accept, dup, grant-ack, fill and parent-done strobes.
- The top level holds the comparators, the round-robin arbiter and output muxing.

Test Plan:
- Single miss: reset, then miss tid=1 pa=35'h0_1234_5678 -> the next cycle req_vld=1, req_tid=1, req_pa=35'h0_1234_5678. Ack -> req_vld=0. Two fill beats tid=1 -> mil_done=4'b0010 one cycle after the second beat; mil_busy returns to 0.
- Duplicate: miss tid0 pa=A; while tid0 is WAIT, miss tid2 pa=A -> dup_hit=1, and tid2 never appears on req_tid. Fill tid0 twice -> mil_done=4'b0101 in the same cycle.
- Round-robin: misses to tids 0, 1, 2, 3 (distinct pa) with req_ack held high -> req_tid sequence 0, 1, 2, 3. Hold ack low for 3 cycles -> req_pa stays stable.
- Boundary: miss to busy tid 0 -> mil_err=1 and the entry pa is unchanged. Fill for IDLE tid3 -> mil_err=1 and no state change.
- Same-cycle race: tid0 final fill beat in the same cycle as miss tid1 pa=same -> no dup_hit, and tid1 goes to REQ.
- Reset mid-operation: reset asserted with tid0 in FILL1 and tid2 in REQ -> the next cycle mil_busy=0, req_vld=0 and all pulses 0. A subsequent fill tid0 -> mil_err=1.
